// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: timing defaults and the sync decoder state type,
// shared by the VGA timing generator and sync_pulse_decoder.
package vga_timing_pkg;

  localparam int unsigned DEF_TOTAL_COLS    = 800;
  localparam int unsigned DEF_ACTIVE_COLS   = 640;
  localparam int unsigned DEF_H_FRONT_PORCH = 16;
  localparam int unsigned DEF_H_BACK_PORCH  = 48;

  localparam int unsigned DEF_TOTAL_ROWS    = 525;
  localparam int unsigned DEF_ACTIVE_ROWS   = 480;
  localparam int unsigned DEF_V_FRONT_PORCH = 10;
  localparam int unsigned DEF_V_BACK_PORCH  = 33;

  localparam int unsigned DEF_LOCK_LINES    = 4;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } sync_state_e;

  function automatic logic [7:0] sat_inc8(
    input logic [7:0] v
  );
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: registers one sync line and flags its rising edge.
// The register idles high so a line held high through reset never rises.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sync_in,
  output logic sync_q,
  output logic rise
);

  always_ff @(posedge clk) begin
    if (rst) sync_q <= 1'b1;
    else     sync_q <= sync_in;
  end

  assign rise = ~sync_q & sync_in;

endmodule

// File: rtl/sync_pulse_decoder.sv
// sync_pulse_decoder: recovers row/col from HSync/VSync, locks after
// a run of well-timed lines and reports timing violations while locked.
module sync_pulse_decoder
  import vga_timing_pkg::*;
#(
  parameter int unsigned TOTAL_COLS    = DEF_TOTAL_COLS,
  parameter int unsigned ACTIVE_COLS   = DEF_ACTIVE_COLS,
  parameter int unsigned H_FRONT_PORCH = DEF_H_FRONT_PORCH,
  parameter int unsigned H_BACK_PORCH  = DEF_H_BACK_PORCH,
  parameter int unsigned TOTAL_ROWS    = DEF_TOTAL_ROWS,
  parameter int unsigned ACTIVE_ROWS   = DEF_ACTIVE_ROWS,
  parameter int unsigned V_FRONT_PORCH = DEF_V_FRONT_PORCH,
  parameter int unsigned V_BACK_PORCH  = DEF_V_BACK_PORCH,
  parameter int unsigned LOCK_LINES    = DEF_LOCK_LINES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       HSync_in,
  input  logic       VSync_in,
  output logic       HSync,
  output logic       VSync,
  output logic [9:0] row,
  output logic [9:0] col,
  output logic       locked,
  output logic       active,
  output logic       sync_err,
  output logic [7:0] err_count
);

  localparam logic [9:0] HS_END = 10'(TOTAL_COLS - H_BACK_PORCH);
  localparam logic [9:0] VS_END = 10'(TOTAL_ROWS - V_BACK_PORCH);
  localparam logic [9:0] H_LAST = HS_END - 10'd1;
  localparam logic [9:0] V_LAST = VS_END - 10'd1;
  localparam logic [9:0] C_MAX  = 10'(TOTAL_COLS - 1);
  localparam logic [9:0] R_MAX  = 10'(TOTAL_ROWS - 1);
  localparam logic [9:0] ACT_C  = 10'(ACTIVE_COLS);
  localparam logic [9:0] ACT_R  = 10'(ACTIVE_ROWS);
  localparam logic [7:0] LOCK_N = 8'(LOCK_LINES);

  if (ACTIVE_COLS + H_FRONT_PORCH + H_BACK_PORCH >= TOTAL_COLS ||
      ACTIVE_ROWS + V_FRONT_PORCH + V_BACK_PORCH >= TOTAL_ROWS)
  begin : g_bad_timing
    $error("sync_pulse_decoder: porches leave no sync pulse");
  end

  sync_state_e state, state_n;
  logic [9:0]  row_n, col_n;
  logic [9:0]  row_inc, col_inc;
  logic [7:0]  good, good_n;
  logic        h_rise, v_rise;
  logic        at_h, at_v;
  logic        h_err, v_err;
  logic        err;

  sync_edge_det u_hdet (
    .clk     (clk),
    .rst     (rst),
    .sync_in (HSync_in),
    .sync_q  (HSync),
    .rise    (h_rise)
  );

  sync_edge_det u_vdet (
    .clk     (clk),
    .rst     (rst),
    .sync_in (VSync_in),
    .sync_q  (VSync),
    .rise    (v_rise)
  );

  assign col_inc = (col == C_MAX) ? '0 : col + 10'd1;
  assign row_inc = (col != C_MAX) ? row :
                   (row == R_MAX) ? '0 : row + 10'd1;

  // A rise must land exactly where expected, and be present there.
  assign at_h  = (col == H_LAST);
  assign at_v  = (row == V_LAST) && (col == C_MAX);
  assign h_err = h_rise ^ at_h;
  assign v_err = v_rise ^ at_v;

  always_comb begin
    state_n = state;
    col_n   = col_inc;
    row_n   = row_inc;
    good_n  = good;
    err     = 1'b0;
    unique case (state)
      SEARCH: begin
        if (h_rise) begin
          col_n   = HS_END;
          good_n  = '0;
          state_n = TRACK;
        end
      end
      TRACK: begin
        if (h_rise) begin
          if (at_h) begin
            good_n = sat_inc8(good);
          end else begin
            col_n  = HS_END;
            good_n = '0;
          end
        end
        if (v_rise) begin
          row_n = VS_END;
          col_n = '0;
          if (good >= LOCK_N) state_n = LOCKED;
        end
      end
      LOCKED: begin
        if (h_err || v_err) begin
          err     = 1'b1;
          good_n  = '0;
          state_n = SEARCH;
        end
      end
      default: state_n = SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SEARCH;
      row       <= '0;
      col       <= '0;
      good      <= '0;
      err_count <= '0;
      locked    <= 1'b0;
      active    <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      state    <= state_n;
      row      <= row_n;
      col      <= col_n;
      good     <= good_n;
      sync_err <= err;
      if (err) err_count <= sat_inc8(err_count);
      locked   <= (state == LOCKED);
      // Qualified with next row/col so it lines up with the outputs.
      active   <= (state == LOCKED) && (col_n < ACT_C) &&
                  (row_n < ACT_R);
    end
  end

endmodule
